// File: rtl/alu_simd_pkg.sv
// Shared definitions for the SIMD ALU slice: lane-grouping modes, lane width
// and the mapping from USE_SIMD to the lanes that close each lane group.
package alu_simd_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES_DEF = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    mode_16x16     = 2'b00,
    mode_sum_16x16 = 2'b01,
    mode_sum_8x8   = 2'b10,
    mode_sum_4x4   = 2'b11
  } simd_mode_e;

  // A 1 marks the top lane of a group; lane 3 always closes a group.
  function automatic logic [3:0] group_leader_mask(input logic [1:0] use_simd);
    logic [3:0] leader;
    case (use_simd)
      mode_sum_8x8: leader = 4'b1010;
      mode_sum_4x4: leader = 4'b1111;
      default:      leader = 4'b1000;
    endcase
    return leader;
  endfunction

endpackage

// File: rtl/alu_out_patdet.sv
// Combinational pattern / pattern-bar detector: per-lane bit-match reduction
// followed by a lane-group combine; each group result is replicated to its lanes.
module alu_out_patdet
  import alu_simd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic [1:0]       use_simd,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic [LANES-1:0] pd_new,
  output logic [LANES-1:0] pbd_new
);

  localparam int LW = WIDTH / LANES;

  logic [WIDTH-1:0] bit_m;
  logic [WIDTH-1:0] bit_mb;
  logic [LANES-1:0] lane_m;
  logic [LANES-1:0] lane_mb;
  logic [LANES-1:0] leader;
  logic [LANES-1:0] seg_m;
  logic [LANES-1:0] seg_mb;

  // A bit equals ~PATTERN exactly when it differs from PATTERN.
  assign bit_m  = mask | ~(s ^ pattern);
  assign bit_mb = mask | (s ^ pattern);
  assign leader = group_leader_mask(use_simd);

  always_comb begin
    lane_m  = '0;
    lane_mb = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_m[l]  = &bit_m[l*LW +: LW];
      lane_mb[l] = &bit_mb[l*LW +: LW];
    end
  end

  // seg_* accumulates the AND from the bottom of the current group up to lane l,
  // so at a leader lane it holds the whole-group result.
  always_comb begin
    seg_m     = '0;
    seg_mb    = '0;
    seg_m[0]  = lane_m[0];
    seg_mb[0] = lane_mb[0];
    for (int l = 1; l < LANES; l++) begin
      seg_m[l]  = lane_m[l]  & (leader[l-1] | seg_m[l-1]);
      seg_mb[l] = lane_mb[l] & (leader[l-1] | seg_mb[l-1]);
    end
  end

  // Broadcast each leader's group result down to the lanes below it.
  always_comb begin
    pd_new           = '0;
    pbd_new          = '0;
    pd_new[LANES-1]  = seg_m[LANES-1];
    pbd_new[LANES-1] = seg_mb[LANES-1];
    for (int l = LANES - 2; l >= 0; l--) begin
      pd_new[l]  = leader[l] ? seg_m[l]  : pd_new[l+1];
      pbd_new[l] = leader[l] ? seg_mb[l] : pbd_new[l+1];
    end
  end

endmodule

// File: rtl/alu_out_reg_simd.sv
// P output register stage of the SIMD ALU with lane-aware pattern detect and
// DSP48-style overflow/underflow; detect logic is built only with ALU_OUT_PATDET_EN.
module alu_out_reg_simd
  import alu_simd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CEP,
  input  logic             RSTP,
  input  logic [1:0]       USE_SIMD,
  input  logic [WIDTH-1:0] S,
  input  logic [LANES-1:0] result_SIDM_carry_out,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [WIDTH-1:0] MASK,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] PCOUT,
  output logic [LANES-1:0] CARRYOUT,
  output logic [LANES-1:0] PATTERNDETECT,
  output logic [LANES-1:0] PATTERNBDETECT,
  output logic [LANES-1:0] OVERFLOW,
  output logic [LANES-1:0] UNDERFLOW,
  output logic [LANES-1:0] OVERFLOW_STICKY
);

  logic [WIDTH-1:0] p_q;
  logic [LANES-1:0] carry_q;

  // Carries pass through untouched; only group-top lanes are meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      carry_q <= '0;
    end else if (RSTP) begin
      p_q     <= '0;
      carry_q <= '0;
    end else if (CEP) begin
      p_q     <= S;
      carry_q <= result_SIDM_carry_out;
    end
  end

  assign P        = p_q;
  assign PCOUT    = p_q;
  assign CARRYOUT = carry_q;

`ifdef ALU_OUT_PATDET_EN

  logic [1:0]       simd_q;
  logic [LANES-1:0] pd_q;
  logic [LANES-1:0] pbd_q;
  logic [LANES-1:0] ovf_q;
  logic [LANES-1:0] unf_q;
  logic [LANES-1:0] sticky_q;
  logic [LANES-1:0] pd_new;
  logic [LANES-1:0] pbd_new;
  logic [LANES-1:0] pd_past;
  logic [LANES-1:0] pbd_past;
  logic [LANES-1:0] ovf_new;
  logic [LANES-1:0] unf_new;
  logic             mode_same;

  alu_out_patdet #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_patdet (
    .use_simd (USE_SIMD),
    .s        (S),
    .pattern  (PATTERN),
    .mask     (MASK),
    .pd_new   (pd_new),
    .pbd_new  (pbd_new)
  );

  // History from a different lane grouping is meaningless, so it is ignored.
  assign mode_same = (USE_SIMD == simd_q);
  assign pd_past   = mode_same ? pd_q  : '0;
  assign pbd_past  = mode_same ? pbd_q : '0;
  assign ovf_new   = pd_past  & ~pd_new & ~pbd_new;
  assign unf_new   = pbd_past & ~pd_new & ~pbd_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      simd_q   <= '0;
      pd_q     <= '0;
      pbd_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      sticky_q <= '0;
    end else if (RSTP) begin
      simd_q   <= '0;
      pd_q     <= '0;
      pbd_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      sticky_q <= '0;
    end else if (CEP) begin
      simd_q   <= USE_SIMD;
      pd_q     <= pd_new;
      pbd_q    <= pbd_new;
      ovf_q    <= ovf_new;
      unf_q    <= unf_new;
      sticky_q <= sticky_q | ovf_new | unf_new;
    end
  end

  assign PATTERNDETECT   = pd_q;
  assign PATTERNBDETECT  = pbd_q;
  assign OVERFLOW        = ovf_q;
  assign UNDERFLOW       = unf_q;
  assign OVERFLOW_STICKY = sticky_q;

`else

  logic unused_patdet_inputs;
  assign unused_patdet_inputs = ^{USE_SIMD, PATTERN, MASK};

  assign PATTERNDETECT   = '0;
  assign PATTERNBDETECT  = '0;
  assign OVERFLOW        = '0;
  assign UNDERFLOW       = '0;
  assign OVERFLOW_STICKY = '0;

`endif

endmodule

// File: tb/tb_alu_out_reg_simd.sv
// Randomized plus directed bench for alu_out_reg_simd against a lane-group
// reference model; flag expectations follow ALU_OUT_PATDET_EN.
module tb_alu_out_reg_simd;

  logic        clk;
  logic        rst;
  logic        CEP;
  logic        RSTP;
  logic [1:0]  USE_SIMD;
  logic [31:0] S;
  logic [3:0]  carry_in;
  logic [31:0] PATTERN;
  logic [31:0] MASK;
  logic [31:0] P;
  logic [31:0] PCOUT;
  logic [3:0]  CARRYOUT;
  logic [3:0]  PATTERNDETECT;
  logic [3:0]  PATTERNBDETECT;
  logic [3:0]  OVERFLOW;
  logic [3:0]  UNDERFLOW;
  logic [3:0]  OVERFLOW_STICKY;

  int checks;
  int failures;

  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] m_p;
  logic [3:0]  m_co, m_pd, m_pbd, m_ovf, m_unf, m_sticky;
  logic [1:0]  m_mode;

  alu_out_reg_simd dut (
    .clk                   (clk),
    .rst                   (rst),
    .CEP                   (CEP),
    .RSTP                  (RSTP),
    .USE_SIMD              (USE_SIMD),
    .S                     (S),
    .result_SIDM_carry_out (carry_in),
    .PATTERN               (PATTERN),
    .MASK                  (MASK),
    .P                     (P),
    .PCOUT                 (PCOUT),
    .CARRYOUT              (CARRYOUT),
    .PATTERNDETECT         (PATTERNDETECT),
    .PATTERNBDETECT        (PATTERNBDETECT),
    .OVERFLOW              (OVERFLOW),
    .UNDERFLOW             (UNDERFLOW),
    .OVERFLOW_STICKY       (OVERFLOW_STICKY)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Group detect straight from the lane-grouping rule: lane l belongs to the
  // aligned block of gsize lanes; compare every unmasked bit of that block.
  function automatic logic [3:0] group_detect(input logic [1:0] mode, input logic [31:0] s,
                                              input logic [31:0] pat, input logic [31:0] msk,
                                              input bit bar);
    logic [3:0]  res;
    logic [31:0] ref_v;
    logic [31:0] gbits;
    int          gsize;
    int          g0;
    gsize = (mode < 2) ? 4 : ((mode == 2) ? 2 : 1);
    ref_v = bar ? ~pat : pat;
    res   = '0;
    for (int l = 0; l < 4; l++) begin
      g0    = (l / gsize) * gsize;
      gbits = '0;
      for (int b = g0 * 8; b < (g0 + gsize) * 8; b++) gbits[b] = 1'b1;
      res[l] = (((s ^ ref_v) & ~msk & gbits) == 32'h0);
    end
    return res;
  endfunction

  task automatic model_reset();
    m_p = '0; m_co = '0; m_pd = '0; m_pbd = '0;
    m_ovf = '0; m_unf = '0; m_sticky = '0; m_mode = '0;
  endtask

  task automatic model_step();
    logic [3:0] pdn, pbdn, past_pd, past_pbd;
    if (RSTP) begin
      model_reset();
    end else if (CEP) begin
      m_p  = S;
      m_co = carry_in;
`ifdef ALU_OUT_PATDET_EN
      pdn      = group_detect(USE_SIMD, S, PATTERN, MASK, 1'b0);
      pbdn     = group_detect(USE_SIMD, S, PATTERN, MASK, 1'b1);
      past_pd  = (USE_SIMD == m_mode) ? m_pd  : 4'h0;
      past_pbd = (USE_SIMD == m_mode) ? m_pbd : 4'h0;
      m_ovf    = past_pd  & ~pdn & ~pbdn;
      m_unf    = past_pbd & ~pdn & ~pbdn;
      m_sticky = m_sticky | m_ovf | m_unf;
      m_pd     = pdn;
      m_pbd    = pbdn;
      m_mode   = USE_SIMD;
`else
      pdn = '0; pbdn = '0; past_pd = '0; past_pbd = '0;
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_p;
    if (exp_q.size() == 0) begin
      check({tag, ":queue"}, 32'h1, 32'h0);
      exp_p = m_p;
    end else begin
      exp_p = exp_q.pop_front();
    end
    check({tag, ":P"},      P,               exp_p);
    check({tag, ":PCOUT"},  PCOUT,           exp_p);
    check({tag, ":CO"},     {28'h0, CARRYOUT},        {28'h0, m_co});
    check({tag, ":PD"},     {28'h0, PATTERNDETECT},   {28'h0, m_pd});
    check({tag, ":PBD"},    {28'h0, PATTERNBDETECT},  {28'h0, m_pbd});
    check({tag, ":OVF"},    {28'h0, OVERFLOW},        {28'h0, m_ovf});
    check({tag, ":UNF"},    {28'h0, UNDERFLOW},       {28'h0, m_unf});
    check({tag, ":STICKY"}, {28'h0, OVERFLOW_STICKY}, {28'h0, m_sticky});
  endtask

  // Driver: inputs are already set; advance one edge and compare.
  task automatic step(input string tag);
    model_step();
    exp_q.push_back(m_p);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic cep, input logic rstp, input logic [1:0] mode,
                       input logic [31:0] s, input logic [3:0] co,
                       input logic [31:0] pat, input logic [31:0] msk);
    CEP = cep; RSTP = rstp; USE_SIMD = mode; S = s; carry_in = co;
    PATTERN = pat; MASK = msk;
  endtask

  task automatic pick_random();
    logic [31:0] pat, msk, s, rnd;
    int sel;
    pat = $urandom;
    case ($urandom_range(0, 3))
      0: msk = 32'h0;
      1: msk = 32'h3F3F3F3F;
      2: msk = 32'h3FFFFFFF;
      default: msk = 32'h0F0F0F0F;
    endcase
    rnd = $urandom;
    sel = $urandom_range(0, 4);
    case (sel)
      0: s = (pat & ~msk) | (rnd & msk);
      1: s = (~pat & ~msk) | (rnd & msk);
      2: s = ((pat & ~msk) | (rnd & msk)) ^ (32'h1 << $urandom_range(0, 31));
      3: s = ((~pat & ~msk) | (rnd & msk)) ^ (32'h1 << $urandom_range(0, 31));
      default: s = rnd;
    endcase
    CEP      = ($urandom_range(0, 7) != 0);
    RSTP     = ($urandom_range(0, 31) == 0);
    if ($urandom_range(0, 9) == 0) USE_SIMD = 2'($urandom_range(0, 3));
    S        = s;
    carry_in = 4'($urandom_range(0, 15));
    PATTERN  = pat;
    MASK     = msk;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #3;
    model_reset();
    exp_q.push_back(32'h0);
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic capture and hold
    drive(1'b1, 1'b0, 2'b00, 32'h12345678, 4'b1010, 32'h0, 32'h0);
    step("capture");
    check("capture_lit", P, 32'h12345678);
    drive(1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 4'b0101, 32'h0, 32'h0);
    step("hold");
    check("hold_lit", P, 32'h12345678);

    // Full-width overflow, then RSTP clear
    drive(1'b1, 1'b0, 2'b00, 32'h00001000, 4'h0, 32'h0, 32'h3FFFFFFF);
    step("ovf_a");
    drive(1'b1, 1'b0, 2'b00, 32'h40000000, 4'h0, 32'h0, 32'h3FFFFFFF);
    step("ovf_b");
`ifdef ALU_OUT_PATDET_EN
    check("ovf_lit", {28'h0, OVERFLOW}, 32'hF);
    check("sticky_lit", {28'h0, OVERFLOW_STICKY}, 32'hF);
`endif
    drive(1'b1, 1'b1, 2'b00, 32'h55555555, 4'hF, 32'h0, 32'h3FFFFFFF);
    step("rstp");
    check("rstp_lit", P, 32'h0);

    // Mode 11 per-lane underflow
    drive(1'b1, 1'b0, 2'b11, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h3F3F3F3F);
    step("unf_a");
    drive(1'b1, 1'b0, 2'b11, 32'hFF80FFFF, 4'h0, 32'h0, 32'h3F3F3F3F);
    step("unf_b");
`ifdef ALU_OUT_PATDET_EN
    check("unf_lit", {28'h0, UNDERFLOW}, 32'h4);
`endif

    // Mode 10 grouping
    drive(1'b1, 1'b0, 2'b10, 32'h0000FFFF, 4'h0, 32'h0000FFFF, 32'h0);
    step("grp_a");
    drive(1'b1, 1'b0, 2'b10, 32'h0001FFFF, 4'h0, 32'h0000FFFF, 32'h0);
    step("grp_b");
`ifdef ALU_OUT_PATDET_EN
    check("grp_lit", {28'h0, PATTERNDETECT}, 32'h3);
`endif

    // Mode change on the flagging cycle suppresses flags
    drive(1'b1, 1'b0, 2'b11, 32'h0, 4'h0, 32'h0, 32'h3F3F3F3F);
    step("mchg_a");
    drive(1'b1, 1'b0, 2'b00, 32'h40404040, 4'h0, 32'h0, 32'h3F3F3F3F);
    step("mchg_b");
    check("mchg_ovf", {28'h0, OVERFLOW}, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pick_random();
      step("rand");
    end

    // Asynchronous reset between edges
    drive(1'b1, 1'b0, 2'b00, 32'hA5A5A5A5, 4'hF, 32'h0, 32'h0);
    step("pre_async");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(32'h0);
    check_outputs("async_rst");
    #2;
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 32'h00000001, 4'h1, 32'h0, 32'h0);
    step("post_async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_out_reg_simd.md
# alu_out_reg_simd

Output register stage directly downstream of the SIMD ALU. It captures the 32-bit ALU sum `S` and the per-lane carry-outs into the P register. It performs SIMD-aware pattern and pattern-bar detection, with DSP48-style overflow/underflow derived from the previous cycle's detect state. P is fed back to the ALU Z-operand mux and forwarded as the cascade output.

## Interface
- `WIDTH`, 32, datapath width.
- `LANES`, 4, number of SIMD lanes; lane width is `WIDTH/LANES` = 8.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset; clears all state.
- `CEP` in 1: clock enable for every register in the block.
- `RSTP` in 1: synchronous clear of P, carry and detect state; has priority over `CEP`.
- `USE_SIMD` in 2: lane grouping, same encoding the ALU uses.
- `S` in 32: sum from the ALU.
- `result_SIDM_carry_out` in 4: per-lane carry-out from the ALU.
- `PATTERN` in 32: compare pattern.
- `MASK` in 32: a 1 marks a bit ignored in the compare.
- `P` out 32: registered result; also the Z-mux feedback source.
- `PCOUT` out 32: cascade output, equal to `P`.
- `CARRYOUT` out 4: registered per-lane carry.
- `PATTERNDETECT` out 4: per lane, the detect result of the group containing that lane.
- `PATTERNBDETECT` out 4: per lane, the pattern-bar detect result of that lane's group.
- `OVERFLOW` out 4: per-lane overflow flag.
- `UNDERFLOW` out 4: per-lane underflow flag.
- `OVERFLOW_STICKY` out 4: per-lane sticky OR of `OVERFLOW | UNDERFLOW`.

## Operation
- Lane groups by `USE_SIMD`:
  - 00 (mode_16x16) and 01 (mode_sum_16x16): one group, lanes 0-3.
  - 10 (mode_sum_8x8): two groups, {0,1} and {2,3}.
  - 11 (mode_sum_4x4): four single-lane groups.
- Bit match: `m[i] = MASK[i] | (S[i] == PATTERN[i])`.
- Bar match: `mb[i] = MASK[i] | (S[i] == ~PATTERN[i])`.
- Group detect is the AND of `m` over all bits in the group; group bar-detect is the AND of `mb`. Each result is replicated to every lane bit of its group.
- Per lane, `pd_past` and `pbd_past` hold the detect and bar-detect values registered on the previous enabled cycle.
- `OVERFLOW = pd_past & ~pd_new & ~pbd_new`.
- `UNDERFLOW = pbd_past & ~pd_new & ~pbd_new`.
- The sticky flag sets on any `OVERFLOW` or `UNDERFLOW` and clears only on `rst` or `RSTP`.
- `USE_SIMD` is registered as `simd_q`. If `USE_SIMD != simd_q` on an enabled cycle, `pd_past`/`pbd_past` are treated as 0, so no spurious flags appear across a mode change.
- Priority per edge: `rst` (async) > `RSTP` > `CEP` > hold.
- `CARRYOUT[i]` registers `result_SIDM_carry_out[i]` unmodified. Only the top lane of each group carries a meaningful carry; lower lanes are passed through as-is.

## Timing
- Latency: `S` to `P` is 1 cycle. All detect and flag outputs are registered and valid in the same cycle as the `P` they describe.
- Reset value of every output is 0, including `simd_q`, `pd_past` and `pbd_past`.
- `CEP=0`: every register holds, including past-detect and sticky state.
- `RSTP=1` and `CEP=1` together: the clear wins and P reads 0 next cycle. The next enabled cycle then sees `pd_past`/`pbd_past` = 0.
- If `rst` asserts mid-accumulation, all outputs go to 0 immediately (asynchronous).
- First enabled cycle after reset cannot flag overflow or underflow.

## Configuration
- Macro: `ALU_OUT_PATDET_EN`.
- Defined: pattern detect, overflow/underflow and sticky logic are compiled in as specified above.
- Undefined:
  - `PATTERNDETECT`, `PATTERNBDETECT`, `OVERFLOW`, `UNDERFLOW` and `OVERFLOW_STICKY` are tied to 0.
  - `PATTERN` and `MASK` stay as ports but are unused.
  - P and carry behaviour is unchanged.

## Structure
- Shared package `alu_simd_pkg`:
  - mode constants mode_16x16, mode_sum_16x16, mode_sum_8x8, mode_sum_4x4;
  - `LANE_W` = 8;
  - a function mapping `USE_SIMD` to a 4-bit lane-group-leader mask.
- One sub-module, `alu_out_patdet`: combinational per-lane match reduction plus group combine, producing `pd_new`/`pbd_new`. It is instantiated only under `ALU_OUT_PATDET_EN`.

## Test plan
- Basic capture: `rst` pulse, then `CEP=1`, `S=0x12345678`, carry `4'b1010` -> next cycle `P=PCOUT=0x12345678`, `CARRYOUT=4'b1010`; with `CEP=0` and a new `S`, P holds.
- Full-width overflow: `USE_SIMD=00`, `PATTERN=0`, `MASK=0x3FFFFFFF`.
  - Drive `S=0x00001000`, then `S=0x40000000` -> second cycle `OVERFLOW=4'b1111`, sticky `4'b1111`.
  - Then `RSTP` -> all outputs 0.
- Mode 11 per-lane underflow: `PATTERN=0`, `MASK=0x3F3F3F3F`.
  - Drive `S=0xFFFFFFFF`, then `S=0xFF80FFFF` -> `UNDERFLOW=4'b0100`, `OVERFLOW=0`.
- Mode 10 grouping: `PATTERN=0x0000FFFF`, `MASK=0` -> `S=0x0000FFFF` gives `PATTERNDETECT=4'b1111`; `S=0x0001FFFF` gives `4'b0011`.
- Mode-change suppression: set up an overflow-eligible history in mode 11, then switch to 00 on the flagging cycle -> `OVERFLOW=0`, `UNDERFLOW=0`.
- Async reset mid-stream: assert `rst` between edges -> P, `CARRYOUT` and all flags read 0 before the next edge.
